// File: rtl/ps2_key_receiver_pkg.sv
// rtl/ps2_key_receiver_pkg.sv - shared definitions: receiver FSM encodings, CPU opcodes, parity helper
package ps2_key_receiver_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [5:0] OP_NOP     = 6'h00;
  localparam logic [5:0] OP_READKEY = 6'h2A;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// rtl/ps2_key_receiver_if.sv - pin, CPU read and status signals of the PS/2 key receiver
interface ps2_key_receiver_if;
  logic       iPS2Clock;
  logic       iPS2Data;
  logic       iRead;
  logic       iClearErrors;
  logic [7:0] oKeyCode;
  logic       oValid;
  logic       oParityError;
  logic       oFrameError;
  logic       oOverflow;

  modport master (
    output iPS2Clock, iPS2Data, iRead, iClearErrors,
    input  oKeyCode, oValid, oParityError, oFrameError, oOverflow
  );

  modport slave (
    input  iPS2Clock, iPS2Data, iRead, iClearErrors,
    output oKeyCode, oValid, oParityError, oFrameError, oOverflow
  );
endinterface

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - show-ahead byte FIFO; head reads 8'h00 while empty
module ps2_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // a pop frees the slot the pointer-aligned push writes into when full
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame receiver with key code FIFO and sticky error flags
module ps2_key_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              Clock,
  input logic              Reset,
  ps2_key_receiver_if.slave io_ps2
);
  import ps2_key_receiver_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          r_ps2c_meta, r_ps2c_sync, r_ps2c_prev;
  logic          r_ps2d_meta, r_ps2d_sync;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [CW-1:0] r_idle_cnt;
  logic          r_parity_err, r_frame_err, r_overflow;

  logic w_fall, w_stop_edge, w_par_ok, w_timeout;
  logic w_push, w_full, w_empty;
  logic w_par_evt, w_frame_evt, w_ovf_evt;

  assign w_fall      = r_ps2c_prev & ~r_ps2c_sync;
  assign w_stop_edge = (r_state == ST_STOP) & w_fall;
  assign w_par_ok    = odd_parity_ok(r_shift, r_parity);
  assign w_timeout   = (r_state != ST_IDLE) & ~w_fall & (r_idle_cnt == TO_LAST);

  // parity failure masks a bad stop bit so only one flag reports the frame
  assign w_push      = w_stop_edge & w_par_ok & r_ps2d_sync;
  assign w_par_evt   = w_stop_edge & ~w_par_ok;
  assign w_frame_evt = w_timeout | (w_stop_edge & w_par_ok & ~r_ps2d_sync);
  assign w_ovf_evt   = w_push & w_full & ~io_ps2.iRead;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ps2c_meta  <= 1'b1;
      r_ps2c_sync  <= 1'b1;
      r_ps2c_prev  <= 1'b1;
      r_ps2d_meta  <= 1'b1;
      r_ps2d_sync  <= 1'b1;
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_idle_cnt   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_ps2c_meta <= io_ps2.iPS2Clock;
      r_ps2c_sync <= r_ps2c_meta;
      r_ps2c_prev <= r_ps2c_sync;
      r_ps2d_meta <= io_ps2.iPS2Data;
      r_ps2d_sync <= r_ps2d_meta;

      case (r_state)
        ST_IDLE: if (w_fall && !r_ps2d_sync) begin
          r_state   <= ST_DATA;
          r_bit_cnt <= '0;
        end
        ST_DATA: if (w_fall) begin
          r_shift   <= {r_ps2d_sync, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
        end
        ST_PARITY: if (w_fall) begin
          r_parity <= r_ps2d_sync;
          r_state  <= ST_STOP;
        end
        default: if (w_fall) r_state <= ST_IDLE;
      endcase

      if (r_state == ST_IDLE || w_fall || w_timeout) r_idle_cnt <= '0;
      else                                          r_idle_cnt <= r_idle_cnt + 1'b1;

      if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end

      if (w_par_evt)                r_parity_err <= 1'b1;
      else if (io_ps2.iClearErrors) r_parity_err <= 1'b0;
      if (w_frame_evt)              r_frame_err  <= 1'b1;
      else if (io_ps2.iClearErrors) r_frame_err  <= 1'b0;
      if (w_ovf_evt)                r_overflow   <= 1'b1;
      else if (io_ps2.iClearErrors) r_overflow   <= 1'b0;
    end
  end

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (io_ps2.iRead),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (io_ps2.oKeyCode)
  );

  assign io_ps2.oValid       = ~w_empty;
  assign io_ps2.oParityError = r_parity_err;
  assign io_ps2.oFrameError  = r_frame_err;
  assign io_ps2.oOverflow    = r_overflow;
endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffered key codes (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the inter-edge frame timeout (1 ms at 50 MHz Clock).
REQ-003 SHALL have port Clock  input  1  system clock; single clock domain, all state updates on posedge.
REQ-004 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port iPS2Clock  input  1  asynchronous PS/2 clock line from pin.
REQ-006 SHALL have port iPS2Data  input  1  asynchronous PS/2 data line from pin.
REQ-007 SHALL have port iRead  input  1  pop request from CPU READKEY instruction decode.
REQ-008 SHALL have port iClearErrors  input  1  clears sticky error flags.
REQ-009 SHALL have port oKeyCode  output  8  head-of-FIFO scan code (show-ahead).
REQ-010 SHALL have port oValid  output  1  FIFO non-empty.
REQ-011 SHALL have port oParityError  output  1  sticky parity error flag.
REQ-012 SHALL have port oFrameError  output  1  sticky stop-bit or timeout error flag.
REQ-013 SHALL have port oOverflow  output  1  sticky flag, byte dropped because FIFO full.

Function
REQ-014 SHALL synchronize iPS2Clock and iPS2Data through two flip-flops each before any use.
REQ-015 SHALL generate a one-cycle falling-edge pulse when the synchronized clock was 1 last cycle and is 0 this cycle; all bit sampling uses synchronized data on that pulse.
REQ-016 SHALL implement FSM IDLE, DATA, PARITY, STOP, advancing only on edge pulses except for timeout.
REQ-017 IDLE: edge with data=0 (start bit) -> DATA with bit count 0; edge with data=1 -> stay IDLE, no flag set.
REQ-018 DATA: shift bits LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY: sample parity bit -> STOP; frame parity is odd (data ones + parity bit = odd).
REQ-020 STOP: on edge -> IDLE; stop=1 and parity OK -> push byte; parity bad -> set oParityError, discard; stop=0 -> set oFrameError, discard. Parity error takes precedence when both occur.
REQ-021 In any non-IDLE state, an idle counter SHALL clear on each edge pulse; on reaching TIMEOUT_CYCLES -> IDLE, discard partial byte, set oFrameError.
REQ-022 A valid byte SHALL be visible on oKeyCode/oValid on the cycle after the stop-bit edge pulse.
REQ-023 iRead with oValid=1 SHALL pop; the next entry (or oValid=0) appears the following cycle. iRead with oValid=0 SHALL be ignored.
REQ-024 Push while full and no pop SHALL drop the new byte and set oOverflow; FIFO contents unchanged.
REQ-025 Simultaneous push and pop while full SHALL both succeed; count unchanged, no overflow.
REQ-026 Simultaneous push and pop while empty: push stored, pop ignored.
REQ-027 iClearErrors SHALL clear all three sticky flags; an error event in the same cycle wins (flag stays 1).
REQ-028 oKeyCode SHALL read 8'h00 when FIFO empty.

Reset
REQ-029 Reset SHALL force FSM to IDLE, clear bit count, shift register, idle counter, FIFO pointers and count, synchronizer flops to 1, and all outputs to 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no push and no flag; reception restarts at the next start bit after release.

Structure
REQ-031 FSM state encodings and the READKEY opcode SHALL live in the shared definitions include alongside the existing opcodes.
REQ-032 The FIFO SHALL be a separate sub-module ps2_byte_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-033 Send 0x1C (parity 0, stop 1) at 12.5 kHz PS/2 clock -> oValid=1, oKeyCode=0x1C; iRead one cycle -> oValid=0 next cycle.
REQ-034 Send 0xF0 with parity 0 (wrong) -> no push, oParityError=1; iClearErrors -> 0.
REQ-035 Send 0xF0, 0x1C, 0x29, 0x5A, 0x76 without reads -> first four held in order, oOverflow=1; four reads return F0,1C,29,5A.
REQ-036 Send start plus 3 data bits, stall 50000 cycles -> oFrameError=1, FSM IDLE; then send 0x1C -> only 0x1C received.
REQ-037 Assert Reset after 5 data bits of 0x5A, release, send 0x29 -> only 0x29 received, all flags 0.
REQ-038 FIFO full, stop-bit edge coincides with iRead -> head advances, new byte appended, oOverflow=0.
